fastica_unit_sequencer: RTL and testbench



---
 rtl/fastica_unit_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fastica_unit_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fastica_unit_sequencer.sv
// One-unit FastICA fast-clock sequencer: FILL -> MEAN -> TAIL -> SUB -> CHECK per iteration,
// repeated until converged or MAX_ITER. Optional stall input under `FASTICA_SEQ_STALL_EN.
module fastica_unit_sequencer #(
    parameter int N_MUL     = 4,
    parameter int N_SAMPLES = 128,
    parameter int CNT_W     = 8,
    parameter int MAX_ITER  = 16,
    parameter int ITER_W    = 5
) (
    input  logic              clk_fast,
    input  logic              rst_fast,
    input  logic              go_fast,
    input  logic              converged,
    input  logic              abort,
`ifdef FASTICA_SEQ_STALL_EN
    input  logic              stall,
`endif
    output logic              en_b,
    output logic [N_MUL-1:0]  en_mul,
    output logic              en_tail,
    output logic              en_mean,
    output logic              en_sub,
    output logic              fast_busy,
    output logic              done,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam int K_W = (N_MUL > 1) ? $clog2(N_MUL) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_MEAN  = 3'd2,
        S_TAIL  = 3'd3,
        S_SUB   = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CNT_W-1:0]  smp_q, smp_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              to_q, to_d;
    logic [ITER_W-1:0] iter_next;
    logic              stall_req;

`ifdef FASTICA_SEQ_STALL_EN
    assign stall_req = stall;
`else
    assign stall_req = 1'b0;
`endif

    assign iter_next = iter_q + ITER_W'(1);
    assign en_b      = 1'b1;
    assign iter_cnt  = iter_q;
    assign timeout   = to_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        smp_d     = smp_q;
        iter_d    = iter_q;
        to_d      = to_q;
        en_mul    = '0;
        en_tail   = 1'b0;
        en_mean   = 1'b0;
        en_sub    = 1'b0;
        fast_busy = 1'b1;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                fast_busy = 1'b0;
                if (go_fast) begin
                    state_d = S_FILL;
                    iter_d  = '0;
                    to_d    = 1'b0;
                    k_d     = '0;
                end
            end
            S_FILL: begin
                // Thermometer: stages 0..k are enabled as the pipeline fills.
                for (int i = 0; i < N_MUL; i++) begin
                    en_mul[i] = (K_W'(i) <= k_q);
                end
                if (k_q == K_W'(N_MUL - 1)) begin
                    state_d = S_MEAN;
                    smp_d   = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_MEAN: begin
                en_mul  = '1;
                en_mean = 1'b1;
                smp_d   = smp_q + CNT_W'(1);
                if (smp_q == CNT_W'(N_SAMPLES - 2)) begin
                    state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                // Last sample leaves the tail multiplier, so the mean unit stays enabled.
                en_tail = 1'b1;
                en_mean = 1'b1;
                state_d = S_SUB;
            end
            S_SUB: begin
                en_sub  = 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                iter_d = iter_next;
                if (converged) begin
                    state_d = S_DONE;
                end else if (iter_next == ITER_W'(MAX_ITER)) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                end else begin
                    state_d = S_FILL;
                    k_d     = '0;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                fast_busy = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // fast_busy is high exactly in the legal non-idle states, which is where a stall applies.
        if (stall_req && fast_busy) begin
            state_d = state_q;
            k_d     = k_q;
            smp_d   = smp_q;
            iter_d  = iter_q;
            to_d    = to_q;
            en_mul  = '0;
            en_tail = 1'b0;
            en_mean = 1'b0;
            en_sub  = 1'b0;
            done    = 1'b0;
        end

        if (abort) begin
            state_d = S_IDLE;
            k_d     = '0;
            smp_d   = '0;
            iter_d  = iter_q;
            to_d    = to_q;
        end
    end

    always_ff @(posedge clk_fast) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values.
        if (rst_fast) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            smp_q   <= '0;
            iter_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            smp_q   <= smp_d;
            iter_q  <= iter_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_fastica_unit_sequencer.sv
// Scoreboard bench for fastica_unit_sequencer; the stall scenario builds with `FASTICA_SEQ_STALL_EN
// at N_MUL=2, N_SAMPLES=8.
module tb_fastica_unit_sequencer;

`ifdef FASTICA_SEQ_STALL_EN
    localparam int N_MUL     = 2;
    localparam int N_SAMPLES = 8;
`else
    localparam int N_MUL     = 4;
    localparam int N_SAMPLES = 128;
`endif
    localparam int CNT_W    = 8;
    localparam int MAX_ITER = 16;
    localparam int ITER_W   = 5;
    localparam int IT_LEN   = N_MUL + N_SAMPLES + 2;
    localparam int AB_PT    = (N_SAMPLES - 2 < 60) ? N_SAMPLES - 2 : 60;

    logic              clk_fast = 1'b0;
    logic              rst_fast, go_fast, converged, abort, stall;
    logic              en_b, en_tail, en_mean, en_sub, fast_busy, done, timeout;
    logic [N_MUL-1:0]  en_mul;
    logic [ITER_W-1:0] iter_cnt;

    typedef struct {
        int   iter;
        logic to;
        int   cycles;
        int   mean;
        int   sub;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_fast = ~clk_fast;

    fastica_unit_sequencer #(
        .N_MUL(N_MUL), .N_SAMPLES(N_SAMPLES), .CNT_W(CNT_W), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)
    ) dut (
        .clk_fast (clk_fast),
        .rst_fast (rst_fast),
        .go_fast  (go_fast),
        .converged(converged),
        .abort    (abort),
`ifdef FASTICA_SEQ_STALL_EN
        .stall    (stall),
`endif
        .en_b     (en_b),
        .en_mul   (en_mul),
        .en_tail  (en_tail),
        .en_mean  (en_mean),
        .en_sub   (en_sub),
        .fast_busy(fast_busy),
        .done     (done),
        .timeout  (timeout),
        .iter_cnt (iter_cnt)
    );

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    // conv_at = CHECK index that sees converged=1 (0: never); go_mid = cycle after which go pulses.
    task automatic run(input int conv_at, input int go_mid, input bit hold_go,
                       input int stall_at, input int stall_len, input string tag);
        exp_t e, g;
        int   n_it, cyc, mc, sc, st_left;
        bit   seen, st_done, fill_bad, stall_bad, clr_bad;
        logic [N_MUL-1:0] therm;
        n_it     = (conv_at == 0) ? MAX_ITER : conv_at;
        e.iter   = n_it;
        e.to     = (conv_at == 0);
        e.cycles = n_it * IT_LEN + 1 + stall_len;
        e.mean   = n_it * N_SAMPLES;
        e.sub    = n_it;
        sb.push_back(e);
        go_fast = 1'b1; converged = 1'b0; stall = 1'b0;
        cyc = 0; mc = 0; sc = 0; st_left = 0;
        seen = 0; st_done = 0; fill_bad = 0; stall_bad = 0; clr_bad = 0;
        while (!seen && cyc < e.cycles + 50) begin
            tick();
            cyc++;
            if (!hold_go) go_fast = (cyc == go_mid);
            if (cyc == 1 && (iter_cnt !== '0 || timeout !== 1'b0)) clr_bad = 1;
            if (cyc <= N_MUL) begin
                therm = '0;
                for (int i = 0; i < cyc; i++) therm[i] = 1'b1;
                if (en_mul !== therm || en_mean !== 1'b0) fill_bad = 1;
            end
            if (en_mean === 1'b1) mc++;
            if (en_sub === 1'b1) sc++;
            if (en_b !== 1'b1) fill_bad = 1;
            converged = (conv_at != 0 && sc >= conv_at);
            if (st_left > 0) begin
                if (en_mul !== '0 || en_mean !== 1'b0 || en_tail !== 1'b0 || en_sub !== 1'b0 ||
                    fast_busy !== 1'b1 || done !== 1'b0) stall_bad = 1;
                st_left--;
                if (st_left == 0) stall = 1'b0;
            end else if (!st_done && stall_len > 0 && mc == stall_at) begin
                stall = 1'b1; st_left = stall_len; st_done = 1;
            end
            if (done === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s done_wait: no done within %0d cycles", tag, cyc);
        end
        g = sb.pop_front();
        n_checks += 7;
        if (iter_cnt !== ITER_W'(g.iter)) begin
            n_fail++; $display("FAIL %s iter_cnt: got %0d want %0d", tag, iter_cnt, g.iter);
        end
        if (timeout !== g.to) begin
            n_fail++; $display("FAIL %s timeout: got %b want %b", tag, timeout, g.to);
        end
        if (cyc != g.cycles) begin
            n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", tag, cyc, g.cycles);
        end
        if (mc != g.mean) begin
            n_fail++; $display("FAIL %s mean_cycles: got %0d want %0d", tag, mc, g.mean);
        end
        if (sc != g.sub) begin
            n_fail++; $display("FAIL %s sub_cycles: got %0d want %0d", tag, sc, g.sub);
        end
        if (fill_bad) begin
            n_fail++; $display("FAIL %s fill_thermometer: got bad en_mul/en_b pattern want 1,3,7,..", tag);
        end
        if (clr_bad) begin
            n_fail++; $display("FAIL %s go_clears: got iter_cnt/timeout nonzero want 0", tag);
        end
        if (stall_len > 0) begin
            n_checks++;
            if (stall_bad) begin
                n_fail++; $display("FAIL %s stall_outputs: got enables active want all 0", tag);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || fast_busy !== 1'b0) begin
            n_fail++; $display("FAIL %s after_done: got done=%b busy=%b want 0 0", tag, done, fast_busy);
        end
        if (hold_go) begin
            tick();
            n_checks++;
            if (en_mul !== N_MUL'(1) || fast_busy !== 1'b1) begin
                n_fail++; $display("FAIL %s restart: got en_mul=%b busy=%b want 1 1", tag, en_mul, fast_busy);
            end
            go_fast = 1'b0; abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        go_fast = 1'b0; converged = 1'b0;
    endtask

    task automatic test_reset();
        rst_fast = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (en_b !== 1'b1 || en_mul !== '0 || en_tail !== 1'b0 || en_mean !== 1'b0 || en_sub !== 1'b0 ||
            fast_busy !== 1'b0 || done !== 1'b0 || iter_cnt !== '0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got b=%b mul=%b busy=%b done=%b it=%0d to=%b want 1 0 0 0 0 0",
                     en_b, en_mul, fast_busy, done, iter_cnt, timeout);
        end
        rst_fast = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int cyc, mc;
        go_fast = 1'b1; converged = 1'b0; cyc = 0; mc = 0;
        while (mc < N_SAMPLES + AB_PT + 1 && cyc < 3 * IT_LEN) begin
            tick(); cyc++;
            go_fast = 1'b0;
            if (en_mean === 1'b1) mc++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (fast_busy !== 1'b0 || done !== 1'b0 || en_mul !== '0 || iter_cnt !== ITER_W'(1)) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b done=%b mul=%b it=%0d want 0 0 0 1",
                     fast_busy, done, en_mul, iter_cnt);
        end
        cyc = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1 || fast_busy === 1'b1) cyc++;
        end
        n_checks++;
        if (cyc != 0) begin
            n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", cyc);
        end
        run(1, 0, 0, 0, 0, "after_abort");
    endtask

    task automatic test_reset_mid_run();
        int cyc, bad;
        go_fast = 1'b1; converged = 1'b0; cyc = 0;
        while (en_tail !== 1'b1 && cyc < 2 * IT_LEN) begin
            tick(); cyc++;
            go_fast = (cyc == 3);
        end
        rst_fast = 1'b1;
        tick();
        rst_fast = 1'b0;
        n_checks++;
        if (fast_busy !== 1'b0 || done !== 1'b0 || en_tail !== 1'b0 || en_mean !== 1'b0 ||
            iter_cnt !== '0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_tail: got busy=%b tail=%b mean=%b it=%0d want 0 0 0 0",
                     fast_busy, en_tail, en_mean, iter_cnt);
        end
        bad = 0;
        repeat (2 * IT_LEN) begin
            tick();
            if (fast_busy === 1'b1 || done === 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL reset_no_rerun: got %0d busy cycles want 0", bad);
        end
    endtask

    initial begin
        rst_fast = 1'b1; go_fast = 1'b0; converged = 1'b0; abort = 1'b0; stall = 1'b0;
        test_reset();
        run(1, 0, 0, 0, 0, "single_iter");
        run(0, 0, 0, 0, 0, "timeout_run");
        run(3, 0, 0, 0, 0, "conv_at_3");
        run(2, 5, 0, 0, 0, "go_while_busy");
        test_abort();
        test_reset_mid_run();
        run(1, 0, 1, 0, 0, "back_to_back");
        run(MAX_ITER, 0, 0, 0, 0, "conv_at_last");
`ifdef FASTICA_SEQ_STALL_EN
        run(1, 0, 0, 3, 5, "stall_mean");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
